// File: rtl/morse_stream_decoder.sv
// Morse stream decoder: assembles dit/dash symbols into letters and queues the
// characters in a first-word fall-through FIFO. Define MORSE_DIGITS_EN to decode digits.
module morse_stream_decoder #(
  parameter int MAX_SYMS = 6,
  parameter int DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               pulse_event,
  output logic [5:0]               out_char,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [3:0]  MAX_CNT  = 4'(MAX_SYMS);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [2:0]  EV_DIT   = 3'd1;
  localparam logic [2:0]  EV_DASH  = 3'd2;
  localparam logic [2:0]  EV_ILS   = 3'd3;
  localparam logic [2:0]  EV_IWS   = 3'd4;
  localparam logic [5:0]  CH_SPACE = 6'd0;
  localparam logic [5:0]  CH_UNK   = 6'd63;

  typedef enum logic {IDLE, SPACE_PEND} state_t;

  state_t                state, state_nxt;
  logic [MAX_SYMS-1:0]   pat;
  logic [3:0]            cnt;
  logic                  too_long;
  logic                  last_space;
  logic                  pat_hi;
  logic [5:0]            letter;
  logic                  wr_en, add_sym, clr_letter;
  logic [5:0]            wr_char;

  // Symbols shift in at bit 0, so the low cnt bits read first-symbol-first from the MSB.
  function automatic logic [5:0] lookup(input logic [3:0] n, input logic [4:0] p);
    logic [5:0] c;
    case ({n, p})
      {4'd1, 5'b00000}: c = 6'd5;   // E
      {4'd1, 5'b00001}: c = 6'd20;  // T
      {4'd2, 5'b00000}: c = 6'd9;
      {4'd2, 5'b00001}: c = 6'd1;
      {4'd2, 5'b00010}: c = 6'd14;
      {4'd2, 5'b00011}: c = 6'd13;
      {4'd3, 5'b00000}: c = 6'd19;
      {4'd3, 5'b00001}: c = 6'd21;
      {4'd3, 5'b00010}: c = 6'd18;
      {4'd3, 5'b00011}: c = 6'd23;
      {4'd3, 5'b00100}: c = 6'd4;
      {4'd3, 5'b00101}: c = 6'd11;
      {4'd3, 5'b00110}: c = 6'd7;
      {4'd3, 5'b00111}: c = 6'd15;
      {4'd4, 5'b00000}: c = 6'd8;
      {4'd4, 5'b00001}: c = 6'd22;
      {4'd4, 5'b00010}: c = 6'd6;
      {4'd4, 5'b00100}: c = 6'd12;
      {4'd4, 5'b00110}: c = 6'd16;
      {4'd4, 5'b00111}: c = 6'd10;
      {4'd4, 5'b01000}: c = 6'd2;
      {4'd4, 5'b01001}: c = 6'd24;
      {4'd4, 5'b01010}: c = 6'd3;
      {4'd4, 5'b01011}: c = 6'd25;
      {4'd4, 5'b01100}: c = 6'd26;
      {4'd4, 5'b01101}: c = 6'd17;
`ifdef MORSE_DIGITS_EN
      {4'd5, 5'b11111}: c = 6'd27;
      {4'd5, 5'b01111}: c = 6'd28;
      {4'd5, 5'b00111}: c = 6'd29;
      {4'd5, 5'b00011}: c = 6'd30;
      {4'd5, 5'b00001}: c = 6'd31;
      {4'd5, 5'b00000}: c = 6'd32;
      {4'd5, 5'b10000}: c = 6'd33;
      {4'd5, 5'b11000}: c = 6'd34;
      {4'd5, 5'b11100}: c = 6'd35;
      {4'd5, 5'b11110}: c = 6'd36;
`endif
      default:          c = CH_UNK;
    endcase
    return c;
  endfunction

  // No code is longer than five symbols, so any set bit above that is unmapped.
  if (MAX_SYMS > 5) begin : g_hi
    assign pat_hi = |pat[MAX_SYMS-1:5];
  end else begin : g_no_hi
    assign pat_hi = 1'b0;
  end

  assign letter = (too_long || pat_hi) ? CH_UNK : lookup(cnt, pat[4:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (pulse_event == EV_IWS && cnt != 4'd0) state_nxt = SPACE_PEND;
      SPACE_PEND: state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_en      = 1'b0;
    wr_char    = CH_SPACE;
    add_sym    = 1'b0;
    clr_letter = 1'b0;
    case (state)
      IDLE: begin
        case (pulse_event)
          EV_DIT, EV_DASH: add_sym = 1'b1;
          EV_ILS, EV_IWS: begin
            if (cnt != 4'd0) begin
              wr_en      = 1'b1;
              wr_char    = letter;
              clr_letter = 1'b1;
            end else if (pulse_event == EV_IWS && !last_space) begin
              wr_en = 1'b1;
            end
          end
          default: ;
        endcase
      end
      SPACE_PEND: wr_en = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat        <= '0;
      cnt        <= '0;
      too_long   <= 1'b0;
      last_space <= 1'b1;
    end else begin
      if (clr_letter) begin
        pat      <= '0;
        cnt      <= '0;
        too_long <= 1'b0;
      end else if (add_sym) begin
        if (cnt == MAX_CNT) too_long <= 1'b1;
        else begin
          pat <= {pat[MAX_SYMS-2:0], pulse_event == EV_DASH};
          cnt <= cnt + 4'd1;
        end
      end
      // Tracks the last write decision, whether or not the FIFO had room for it.
      if (wr_en) last_space <= (wr_char == CH_SPACE);
    end
  end

  logic [5:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, do_rd, do_wr;

  assign full       = (count == FULL_CNT);
  assign out_valid  = (count != '0);
  assign out_char   = out_valid ? mem[rd_ptr] : 6'd0;
  assign fifo_count = count;
  assign do_rd      = out_valid && out_ready;
  assign do_wr      = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_char;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
      if (wr_en && full && !do_rd) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_morse_stream_decoder.sv
// Randomized bench for morse_stream_decoder against a string-based Morse model.
module tb_morse_stream_decoder;
  localparam int MAX_SYMS = 6;
  localparam int DEPTH    = 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [2:0]             pulse_event = 3'd0;
  logic                   out_ready = 1'b0;
  logic [5:0]             out_char;
  logic                   out_valid;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   overflow;

  int n_tests = 0;
  int n_fail  = 0;

  morse_stream_decoder #(.MAX_SYMS(MAX_SYMS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pulse_event(pulse_event), .out_char(out_char),
    .out_valid(out_valid), .out_ready(out_ready), .fifo_count(fifo_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  string tbl [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                      ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                      "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                      "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                      "--...", "---..", "----."};

  int    mq[$];
  string cur;
  bit    sp_pend, last_sp, m_ovf;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int decode(input string s);
    if (s.len() > MAX_SYMS) return 63;
    for (int i = 0; i < 26; i++) if (s == tbl[i]) return i + 1;
`ifdef MORSE_DIGITS_EN
    for (int i = 26; i < 36; i++) if (s == tbl[i]) return i + 1;
`endif
    return 63;
  endfunction

  task automatic model_reset();
    mq.delete();
    cur     = "";
    sp_pend = 1'b0;
    last_sp = 1'b1;
    m_ovf   = 1'b0;
  endtask

  task automatic model_step(input int ev, input bit rdy);
    bit wr = 1'b0;
    int w  = 0;
    bit rd = (mq.size() != 0) && rdy;
    if (sp_pend) begin
      wr = 1'b1; w = 0; sp_pend = 1'b0;
    end else if (ev == 1 || ev == 2) begin
      if (cur.len() <= MAX_SYMS) begin
        if (ev == 1) cur = {cur, "."};
        else         cur = {cur, "-"};
      end
    end else if (ev == 3) begin
      if (cur.len() > 0) begin wr = 1'b1; w = decode(cur); cur = ""; end
    end else if (ev == 4) begin
      if (cur.len() > 0) begin wr = 1'b1; w = decode(cur); cur = ""; sp_pend = 1'b1; end
      else if (!last_sp) begin wr = 1'b1; w = 0; end
    end
    if (rd) void'(mq.pop_front());
    if (wr) begin
      last_sp = (w == 0);
      if (mq.size() < DEPTH) mq.push_back(w);
      else m_ovf = 1'b1;
    end
  endtask

  // Entered at posedge+1; compares pre-edge outputs, then advances the model on the edge.
  task automatic step(input int ev, input bit rdy);
    pulse_event = 3'(ev);
    out_ready   = rdy;
    @(negedge clk);
    chk("valid", int'(out_valid), int'(mq.size() != 0));
    chk("count", int'(fifo_count), mq.size());
    chk("ovf", int'(overflow), int'(m_ovf));
    if (mq.size() != 0) chk("char", int'(out_char), mq[0]);
    @(posedge clk);
    model_step(ev, rdy);
    #1;
  endtask

  task automatic apply_reset();
    pulse_event = 3'd0;
    out_ready   = 1'b0;
    #3 rst = 1'b0;
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_char", int'(out_char), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    model_step(0, 1'b0);
    #1;
  endtask

  initial begin
    int rp, r, ev;
    model_reset();
    #12;
    chk("por_valid", int'(out_valid), 0);
    chk("por_count", int'(fifo_count), 0);
    chk("por_ovf", int'(overflow), 0);
    chk("por_char", int'(out_char), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    model_step(0, 1'b0);
    #1;

    // Leading word space is suppressed, then H with immediate consumption
    step(4, 1'b1);
    chk("lead_space", int'(fifo_count), 0);
    repeat (4) step(1, 1'b1);
    step(3, 1'b1);
    chk("h_valid", int'(out_valid), 1);
    chk("h_char", int'(out_char), 8);
    step(0, 1'b1);
    chk("h_gone", int'(out_valid), 0);

    // A, word space, extra word spaces collapse
    step(1, 1'b0); step(2, 1'b0);
    repeat (3) step(4, 1'b0);
    step(0, 1'b0);
    chk("a_count", int'(fifo_count), 2);
    chk("a_char", int'(out_char), 1);
    step(0, 1'b1);
    chk("sp_char", int'(out_char), 0);
    step(0, 1'b1);
    chk("a_empty", int'(out_valid), 0);

    // Too-long letter then E
    repeat (7) step(1, 1'b0);
    step(3, 1'b0);
    step(1, 1'b0); step(3, 1'b0);
    chk("long_count", int'(fifo_count), 2);
    chk("long_char", int'(out_char), 63);
    step(0, 1'b1);
    chk("e_char", int'(out_char), 5);
    step(0, 1'b1);

    // Five dashes: digit zero only when digits are enabled
    repeat (5) step(2, 1'b1);
    step(3, 1'b1);
`ifdef MORSE_DIGITS_EN
    chk("dig0", int'(out_char), 27);
`else
    chk("dig0", int'(out_char), 63);
`endif
    step(0, 1'b1);

    // Nine E's into an eight-deep FIFO with no consumer
    repeat (9) begin step(1, 1'b0); step(3, 1'b0); end
    chk("ovf_count", int'(fifo_count), 8);
    chk("ovf_flag", int'(overflow), 1);
    for (int i = 0; i < 8; i++) begin
      chk("ovf_rd", int'(out_char), 5);
      step(0, 1'b1);
    end
    chk("ovf_drained", int'(out_valid), 0);

    // Reset mid-letter with buffered data discards everything
    repeat (3) begin step(2, 1'b0); step(3, 1'b0); end
    step(1, 1'b0); step(2, 1'b0);
    apply_reset();
    step(1, 1'b0); step(3, 1'b0);
    chk("post_rst_count", int'(fifo_count), 1);
    chk("post_rst_char", int'(out_char), 5);
    chk("post_rst_ovf", int'(overflow), 0);
    step(0, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      rp = ((i / 200) % 2 != 0) ? 1 : 3;
      r  = int'($urandom_range(0, 15));
      if (r <= 5)       ev = 1;
      else if (r <= 9)  ev = 2;
      else if (r <= 11) ev = 3;
      else if (r == 12) ev = 4;
      else if (r == 13) ev = 0;
      else              ev = int'($urandom_range(5, 7));
      if ($urandom_range(0, 599) == 0) apply_reset();
      step(ev, $urandom_range(0, 3) < rp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/morse_stream_decoder.md
MORSE_STREAM_DECODER -- requirements
Module: morse_stream_decoder

Interface
REQ-001 SHALL have parameter MAX_SYMS, default 6, meaning the maximum number of dit/dash symbols per letter; legal range 5..8.
REQ-002 SHALL have parameter DEPTH, default 8, meaning the number of output FIFO entries; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: single system clock, rising-edge active.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port pulse_event, input, 3 bits: 0 nothing, 1 dit, 2 dash, 3 inter_letter_space, 4 inter_word_space, 5..7 treated as nothing.
REQ-006 SHALL have port out_char, output, 6 bits: FIFO head character; 0 space, 1..26 A..Z, 27..36 digits 0..9, 63 unknown/error.
REQ-007 SHALL have port out_valid, output, 1 bit: FIFO non-empty.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer accepts the head entry when out_valid && out_ready at a rising edge.
REQ-009 SHALL have port fifo_count, output, clog2(DEPTH)+1 bits: current FIFO occupancy.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag, set on any dropped write.

Function
REQ-011 SHALL accumulate each dit (0) or dash (1) into a MAX_SYMS-bit pattern register plus a symbol counter, one symbol per cycle in which the code is presented.
REQ-012 SHALL mark the pending letter invalid (too_long) when a symbol arrives with counter == MAX_SYMS; further symbols SHALL be discarded.
REQ-013 On inter_letter_space with counter > 0, SHALL write the decoded character (63 if too_long or pattern unmapped) at that edge, then clear pattern, counter and too_long.
REQ-014 Inter_letter_space with counter == 0 SHALL write nothing.
REQ-015 Latency: out_valid SHALL be high in the cycle immediately after the edge that samples the terminating event, when the FIFO was empty.
REQ-016 On inter_word_space with a pending letter, SHALL write the letter at that edge, enter state SPACE_PEND, and write space (0) at the next edge before returning to IDLE.
REQ-017 On inter_word_space with no pending letter, SHALL write space in the same edge, unless the last character written was already space, in which case it SHALL write nothing (space collapsing).
REQ-018 After reset, the "last written was space" flag SHALL be set, so that a leading word space is suppressed.
REQ-019 Any pulse_event other than nothing that is sampled while in SPACE_PEND SHALL be ignored.
REQ-020 The FIFO SHALL be first-word fall-through, and read and write in the same edge SHALL be allowed at any occupancy, including full.
REQ-021 A write while full with no simultaneous read SHALL be dropped, SHALL set overflow, and SHALL leave contents unchanged.
REQ-022 Pointers SHALL wrap modulo DEPTH, and fifo_count SHALL equal writes minus reads.

Reset
REQ-023 While rst is low, the block SHALL be in state IDLE with out_valid 0, out_char 0, fifo_count 0, overflow 0, pattern, counter and too_long all 0, and last_space 1; reset SHALL take effect asynchronously.
REQ-024 Reset asserted mid-letter or in SPACE_PEND SHALL discard all pending and buffered data.

Configuration
REQ-025 With macro MORSE_DIGITS_EN defined, the five-symbol digit codes SHALL decode to 27..36.
REQ-026 With MORSE_DIGITS_EN undefined, the digit patterns SHALL decode to 63, and the digit lookup logic SHALL be absent.

Verification
REQ-027 Sequence dit x4, inter_letter_space with out_ready=1 -> single entry out_char=8 (H); out_valid high for one cycle.
REQ-028 Sequence dit, dash, inter_word_space, then inter_word_space x2 -> entries 1 (A), 0; no further spaces.
REQ-029 Seven dits, then inter_letter_space with MAX_SYMS=6 -> single entry 63; the next letter dit, inter_letter_space -> 5 (E).
REQ-030 Sequence dash x5, inter_letter_space -> 27 with MORSE_DIGITS_EN defined, and 63 without it.
REQ-031 With out_ready=0, 9 letters E at DEPTH=8 -> fifo_count=8, overflow=1, and the first 8 entries read back as 5.
REQ-032 rst pulsed low after dit, dash; then dit, inter_letter_space -> out_char=5 (E), overflow 0, and no stale entry present.
